// File: rtl/decoder_arbiter_if.sv
// decoder_arbiter_if: requester/consumer handshake bundle for the shared decoder.
interface decoder_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int CODE_W = 4,
    parameter int OUT_W  = 8
);
    localparam int IW = $clog2(NREQ);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*CODE_W-1:0] req_code;
    logic [NREQ-1:0]        req_ready;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [IW-1:0]          resp_id;
    logic [OUT_W-1:0]       resp_data;
    logic                   resp_err;
    modport master (
        output req_valid, req_code, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, resp_err
    );
    modport slave (
        input  req_valid, req_code, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_err
    );
endinterface

// File: rtl/decoder_arbiter.sv
// decoder_arbiter: round-robin arbiter feeding a shared one-cold decoder with a response handshake.
module decoder_arbiter #(
    parameter int NREQ   = 4,
    parameter int CODE_W = 4,
    parameter int OUT_W  = 8,
    parameter int WARM   = 4
) (
    input logic             clk,
    input logic             rst_n,
    decoder_arbiter_if.slave bus,
    output logic            busy
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = (WARM > 1) ? $clog2(WARM) : 1;
    typedef enum logic [1:0] {WARMUP, IDLE, DECODE, RESP} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [IW-1:0] rr_ptr, gidx, id_q;
    logic [CODE_W-1:0] code_q;
    logic [OUT_W-1:0] data_q;
    logic found, xfer, err_q;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // first asserted request at or after rr_ptr, wrapping past NREQ-1
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NREQ; k++)
            if (!found && bus.req_valid[wrap_add(rr_ptr, k)]) begin
                found = 1'b1;
                gidx  = wrap_add(rr_ptr, k);
            end
    end

    assign xfer = (state == IDLE) && found;

    always_comb begin
        bus.req_ready = '0;
        if (xfer) bus.req_ready[gidx] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            WARMUP: state_nx = (cnt == '0) ? IDLE : WARMUP;
            IDLE:   state_nx = found ? DECODE : IDLE;
            DECODE: state_nx = RESP;
            RESP:   state_nx = bus.resp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= WARMUP;
        else        state <= state_nx;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt    <= CW'(WARM - 1);
            rr_ptr <= '0;
            id_q   <= '0;
            code_q <= '0;
            data_q <= '1;
            err_q  <= 1'b0;
        end else begin
            if (state == WARMUP && cnt != '0) cnt <= cnt - 1'b1;
            if (xfer) begin
                code_q <= bus.req_code[gidx*CODE_W +: CODE_W];
                id_q   <= gidx;
                rr_ptr <= wrap_add(gidx, 1);
            end
            if (state == DECODE) begin
                err_q  <= 32'(code_q) >= OUT_W;
                data_q <= (32'(code_q) >= OUT_W) ? '1 : ~(OUT_W'(1) << code_q);
            end
        end

    assign bus.resp_valid = state == RESP;
    assign bus.resp_id    = id_q;
    assign bus.resp_data  = data_q;
    assign bus.resp_err   = err_q;
    assign busy           = state != IDLE;
endmodule

// File: tb/tb_decoder_arbiter.sv
// tb_decoder_arbiter: directed stimulus with a response scoreboard checked by an independent monitor.
module tb_decoder_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    rsp_t sb[$];
    int rtimes[$];

    always #5 clk = ~clk;

    decoder_arbiter_if #(.NREQ(4), .CODE_W(4), .OUT_W(8)) bus();

    decoder_arbiter #(.NREQ(4), .CODE_W(4), .OUT_W(8), .WARM(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: pops the scoreboard on each accepted response, checks hold stability
    initial begin
        rsp_t cur, last, e;
        logic held;
        held = 1'b0;
        last = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !bus.resp_valid) held = 1'b0;
            else begin
                cur = {bus.resp_id, bus.resp_data, bus.resp_err};
                if (held) chk("resp_stable", cur, last);
                if (bus.resp_ready) begin
                    rtimes.push_back(cyc);
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_resp: got id %0d data %h err %b, none expected",
                                 bus.resp_id, bus.resp_data, bus.resp_err);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_id", bus.resp_id, e.id);
                        chk("resp_data", bus.resp_data, e.data);
                        chk("resp_err", bus.resp_err, e.err);
                    end
                    held = 1'b0;
                end else begin
                    last = cur;
                    held = 1'b1;
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic set_code(input int i, input logic [3:0] c);
        bus.req_code[i*4 +: 4] = c;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.req_valid = '0;
        step;
        rst_n = 1'b1;
        repeat (4) step;
    endtask

    task automatic txn(input logic [3:0] v, input logic [3:0] g, input logic [1:0] id,
                       input logic [7:0] d, input logic e);
        bus.req_valid = v;
        sb.push_back({id, d, e});
        #1 chk("req_ready", bus.req_ready, g);
        step;
        bus.req_valid = '0;
        #1 chk("ready_decode", bus.req_ready, 0);
        step;
        chk("resp_valid", bus.resp_valid, 1);
        step;
    endtask

    initial begin
        bus.req_valid  = 4'b0001;
        bus.req_code   = {4'd3, 4'd2, 4'd1, 4'd0};
        bus.resp_ready = 1'b1;
        repeat (2) step;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_id", bus.resp_id, 0);
        chk("rst_resp_data", bus.resp_data, 8'hFF);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_busy", busy, 1);

        // warm-up with requester 0 already waiting
        sb.push_back({2'd0, 8'hFE, 1'b0});
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("warm_ready", bus.req_ready, 0);
            step;
        end
        chk("first_grant", bus.req_ready, 4'b0001);
        t0 = cyc;
        step;
        bus.req_valid = '0;
        chk("decode_resp_valid", bus.resp_valid, 0);
        step;
        chk("resp_valid_on", bus.resp_valid, 1);
        chk("latency", cyc - t0, 2);
        step;
        chk("idle_busy", busy, 0);

        // round robin with all requesters active
        chk("sb_empty_a", sb.size(), 0);
        do_reset;
        rtimes.delete();
        sb.push_back({2'd0, 8'hFE, 1'b0});
        sb.push_back({2'd1, 8'hFD, 1'b0});
        sb.push_back({2'd2, 8'hFB, 1'b0});
        sb.push_back({2'd3, 8'hF7, 1'b0});
        sb.push_back({2'd0, 8'hFE, 1'b0});
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_grant", bus.req_ready, 4'b0001 << (k % 4));
            step;
            if (k == 4) bus.req_valid = '0;
            step;
            step;
        end
        chk("rr_count", rtimes.size(), 5);
        for (int i = 1; i < rtimes.size(); i++) chk("resp_spacing", rtimes[i] - rtimes[i-1], 3);

        // decode values and out-of-range code
        set_code(2, 4'd5);
        txn(4'b0100, 4'b0100, 2'd2, 8'hDF, 1'b0);
        set_code(2, 4'd7);
        txn(4'b0100, 4'b0100, 2'd2, 8'h7F, 1'b0);
        set_code(2, 4'd9);
        txn(4'b0100, 4'b0100, 2'd2, 8'hFF, 1'b1);

        // rr_ptr is 3: wrap to requester 1, then pointer 2 skips to 3
        txn(4'b0010, 4'b0010, 2'd1, 8'hFD, 1'b0);
        txn(4'b1011, 4'b1000, 2'd3, 8'hF7, 1'b0);

        // backpressure
        set_code(0, 4'd4);
        bus.resp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        sb.push_back({2'd0, 8'hEF, 1'b0});
        #1 chk("bp_grant", bus.req_ready, 4'b0001);
        step;
        bus.req_valid = 4'b0010;
        step;
        for (int k = 0; k < 5; k++) begin
            chk("bp_resp_valid", bus.resp_valid, 1);
            chk("bp_resp_data", bus.resp_data, 8'hEF);
            chk("bp_req_ready", bus.req_ready, 0);
            step;
        end
        bus.resp_ready = 1'b1;
        sb.push_back({2'd1, 8'hFD, 1'b0});
        step;
        chk("bp_exit", bus.resp_valid, 0);
        #1 chk("bp_next_grant", bus.req_ready, 4'b0010);
        step;
        bus.req_valid = '0;
        step;
        step;
        step;

        // reset while a response is pending
        chk("sb_empty_f", sb.size(), 0);
        bus.resp_ready = 1'b0;
        bus.req_valid = 4'b0100;
        step;
        bus.req_valid = '0;
        step;
        chk("pre_abort_valid", bus.resp_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_valid", bus.resp_valid, 0);
        chk("abort_busy", busy, 1);
        chk("abort_data", bus.resp_data, 8'hFF);
        chk("abort_ready", bus.req_ready, 0);
        step;
        bus.resp_ready = 1'b1;
        rst_n = 1'b1;
        repeat (12) step;
        chk("post_abort_valid", bus.resp_valid, 0);
        chk("post_abort_busy", busy, 0);
        chk("sb_empty_end", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end
endmodule
